// File: rtl/cnn_sram_pkg.sv
// cnn_sram_pkg: shared defaults and the fetch-sequencer state type for the
// syncRAM read path.
//   DW_DEF     data width (syncRAM dataOut)
//   KAW_DEF    kernel-address width
//   PAW_DEF    pixel-address width
//   DEPTH_DEF  output FIFO entries
package cnn_sram_pkg;

    localparam int DW_DEF    = 8;
    localparam int KAW_DEF   = 4;
    localparam int PAW_DEF   = 6;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sram_window_fetch_if.sv
// sram_window_fetch_if: syncRAM read bus plus the outgoing pixel stream.
//   CS/WE/RD/kernAddr/pixAddr  fetcher -> syncRAM
//   ramData                    syncRAM -> fetcher
//   outData/outValid/outLast   fetcher -> MAC datapath
//   outReady                   MAC datapath -> fetcher
// master modport is the fetcher side, slave is the RAM/consumer side.
interface sram_window_fetch_if
    import cnn_sram_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int KAW = KAW_DEF,
    parameter int PAW = PAW_DEF
);

    logic           CS;
    logic           WE;
    logic           RD;
    logic [KAW-1:0] kernAddr;
    logic [PAW-1:0] pixAddr;
    logic [DW-1:0]  ramData;
    logic [DW-1:0]  outData;
    logic           outValid;
    logic           outLast;
    logic           outReady;

    modport master (
        output CS, WE, RD, kernAddr, pixAddr,
        output outData, outValid, outLast,
        input  ramData, outReady
    );

    modport slave (
        input  CS, WE, RD, kernAddr, pixAddr,
        input  outData, outValid, outLast,
        output ramData, outReady
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x W synchronous FIFO carrying {last,data} words.
//   Clk, Rst_n   clock, asynchronous active-low reset (storage cleared)
//   push         write push_data (accepted when not full, or full with pop)
//   pop          remove head (ignored when empty)
//   head         current head word (zero after reset)
//   empty        no entries
//   count        occupancy, used by the issuer for its credit check
module fetch_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sram_window_fetch.sv
// sram_window_fetch: read-side sequencer for syncRAM. A start command walks
// pixCount consecutive pixel addresses (mod 2**PAW) in one kernel bank,
// captures the returned bytes and streams them out with a last flag.
//   Clk, Rst_n   clock, asynchronous active-low reset
//   start        launch a burst (only looked at while idle)
//   kernSel      kernel bank of the burst
//   pixBase      first pixel address
//   pixCount     words to fetch, 0 = empty burst
//   busy         burst in progress
//   done         one-cycle pulse at burst completion (busy already low)
//   bus          master side of the RAM bus and output stream
module sram_window_fetch
    import cnn_sram_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int KAW   = KAW_DEF,
    parameter int PAW   = PAW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                start,
    input  logic [KAW-1:0]      kernSel,
    input  logic [PAW-1:0]      pixBase,
    input  logic [PAW:0]        pixCount,
    output logic                busy,
    output logic                done,
    sram_window_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t         state, state_nx;
    logic [KAW-1:0] kern_q, kern_nx;
    logic [PAW-1:0] addr_q, addr_nx;
    logic [PAW:0]   cnt_q, cnt_nx;
    logic [PAW:0]   issued_q, issued_nx;
    logic [PAW:0]   issued_inc;
    logic           rd_q, rd_nx;
    logic           last_q, last_nx;
    logic           done_q, done_nx;

    // Flag pipe: the read presented this cycle (rd_q) returns data one edge
    // later; cap_v/cap_last mark that the returning byte is pushed next edge.
    logic           cap_v;
    logic           cap_last;

    logic [DW:0]    fifo_head;
    logic           fifo_empty;
    logic [CW-1:0]  occ;
    logic           pop;
    logic [CW:0]    outstanding;
    logic           can_issue;
    logic           drain_empty;

    fetch_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (cap_v),
        .push_data ({cap_last, bus.ramData}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (occ)
    );

    assign pop         = !fifo_empty && bus.outReady;
    // Credit ignores a same-cycle pop, so the FIFO can never overflow.
    assign outstanding = {1'b0, occ} + (CW+1)'(rd_q) + (CW+1)'(cap_v);
    assign can_issue   = outstanding < (CW+1)'(DEPTH);
    // Finish when the last stored word leaves at this edge (or none left),
    // so done lands in the cycle right after the final transfer.
    assign drain_empty = !rd_q && !cap_v &&
                         ((occ == '0) || ((occ == CW'(1)) && pop));
    assign issued_inc  = issued_q + (PAW+1)'(1);

    always_comb begin
        state_nx  = state;
        kern_nx   = kern_q;
        addr_nx   = addr_q;
        cnt_nx    = cnt_q;
        issued_nx = issued_q;
        rd_nx     = 1'b0;
        last_nx   = 1'b0;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    kern_nx = kernSel;
                    cnt_nx  = pixCount;
                    if (pixCount == '0) begin
                        issued_nx = '0;
                        state_nx  = DRAIN;
                    end else begin
                        // First read goes out on the start edge itself.
                        rd_nx     = 1'b1;
                        addr_nx   = pixBase;
                        issued_nx = (PAW+1)'(1);
                        last_nx   = (pixCount == (PAW+1)'(1));
                        state_nx  = last_nx ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if (can_issue) begin
                    rd_nx     = 1'b1;
                    addr_nx   = addr_q + PAW'(1);
                    issued_nx = issued_inc;
                    last_nx   = (issued_inc == cnt_q);
                    if (last_nx) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            kern_q   <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            issued_q <= '0;
            rd_q     <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            cap_v    <= 1'b0;
            cap_last <= 1'b0;
        end else begin
            state    <= state_nx;
            kern_q   <= kern_nx;
            addr_q   <= addr_nx;
            cnt_q    <= cnt_nx;
            issued_q <= issued_nx;
            rd_q     <= rd_nx;
            last_q   <= last_nx;
            done_q   <= done_nx;
            cap_v    <= rd_q;
            cap_last <= last_q;
        end
    end

    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign bus.CS       = rd_q;
    assign bus.RD       = rd_q;
    assign bus.WE       = 1'b0;
    assign bus.kernAddr = kern_q;
    assign bus.pixAddr  = addr_q;
    assign bus.outData  = fifo_head[DW-1:0];
    assign bus.outLast  = fifo_head[DW] && !fifo_empty;
    assign bus.outValid = !fifo_empty;

endmodule
